unified_mem_ctrl: RTL and testbench
===================================

Name: unified_mem_ctrl

Overview:
- Single-port 32-bit data/instruction memory that sits directly downstream of the pipelined CPU core.
- Serves the CPU's instruction-fetch, load and store requests, and returns `instruction_fetch` and `mem_store_data` to the core.
- Arbitrates the one RAM port between the three request classes.
- Posts stores into a small store buffer so they never block, and forwards buffered store data to younger loads.

Parameters:
- ADDR_W, 11, word address width (2048 words)
- DATA_W, 32, data width
- SB_DEPTH, 4, store-buffer entries (power of two, at least 2)
- INIT_FILE, "", hex image loaded with $readmemh at elaboration when non-empty

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- read_mem_ir  in  1  fetch request
- mem_radrs_ir  in  ADDR_W  fetch address
- read_mem_str  in  1  load request; held high by requester while ld_stall=1
- mem_radrs_LD  in  ADDR_W  load address
- write_mem  in  1  store request (single-cycle pulse)
- mem_wadrs  in  ADDR_W  store address
- mem_wdata  in  DATA_W  store data
- instruction_fetch  out  DATA_W  fetched word; 0 (NOOP) when not valid
- ir_valid  out  1  instruction_fetch valid this cycle
- mem_store_data  out  DATA_W  load result
- ld_valid  out  1  mem_store_data valid this cycle
- fetch_stall  out  1  fetch request not granted this cycle; PC must hold
- ld_stall  out  1  load request not accepted this cycle
- sb_count  out  $clog2(SB_DEPTH+1)  store-buffer occupancy
- sb_full  out  1  sb_count == SB_DEPTH
- sb_empty  out  1  sb_count == 0

Behaviour:
- Reset:
  - All outputs go to 0, except sb_empty=1.
  - Store buffer is emptied and pointers are cleared.
  - RAM contents are not cleared.
  - Reset while requests are outstanding discards them; no write completes after reset asserts.
- Store enqueue:
  - write_mem=1 enqueues {mem_wadrs, mem_wdata} at the tail in the same cycle.
  - A store is never refused; the grant rule below guarantees space.
- RAM port grant, evaluated each cycle:
  - sb_full=1: DRAIN (write head entry to RAM). An enqueue in the same cycle is legal (simultaneous enq and deq), so occupancy stays SB_DEPTH.
  - Otherwise, if read_mem_str=1 and the load is accepted: LOAD.
  - Otherwise, if read_mem_ir=1: FETCH.
  - Otherwise, if sb_empty=0: DRAIN.
  - Otherwise: IDLE.
- Grant state is a registered 2-bit encoding {IDLE, FETCH, LOAD, DRAIN}, used to steer the read data returned the following cycle.
- Read latency:
  - A granted read in cycle N returns data in cycle N+1 with ir_valid or ld_valid=1 for exactly one cycle.
  - Forwarded loads use the same N+1 timing.
- Stall outputs (combinational from the current-cycle grant):
  - fetch_stall=1 when read_mem_ir=1 and FETCH is not granted.
  - ld_stall=1 when read_mem_str=1 and the load is not accepted.
  - When ir_valid=0, instruction_fetch is driven to 0.
- Load/store-buffer hazard:
  - A load is compared against every valid buffer entry and against a store enqueueing in the same cycle.
  - The youngest match wins; a same-cycle store is the youngest.
  - Behaviour on a match is set by STORE_FORWARD_EN.
- Drain ordering:
  - Entries drain strictly in FIFO order.
  - Two stores to the same address must both reach RAM in order.
- Pointers: head and tail are log2(SB_DEPTH) bits and wrap modulo SB_DEPTH. sb_count increments on enq-only, decrements on deq-only, and is unchanged on both or neither.
- A load to an address not in the buffer reads RAM and sees only drained data.

Optional Feature:
- Macro: STORE_FORWARD_EN
- Defined:
  - A load matching a buffer entry is accepted without a RAM access; the port remains free for FETCH or DRAIN that cycle.
  - The matching data is registered and returned at N+1 with ld_valid=1.
- Undefined:
  - A matching load is not accepted (ld_stall=1) and grant goes to DRAIN, until no matching entry remains.
  - The load is then accepted as a normal LOAD.

Decomposition:
- Package mem_ctrl_pkg:
  - grant-state enum {GNT_IDLE, GNT_FETCH, GNT_LOAD, GNT_DRAIN}
  - ADDR_W/DATA_W defaults
  - NOOP_WORD = 32'h0
  - store-buffer entry struct {addr, data}
- Sub-module store_buffer: circular FIFO with parallel address CAM.
  - Outputs: youngest-match hit, youngest-match data, head entry, count, full, empty.
- The top level holds the RAM array, the arbiter and the output registers.

Test Plan:
- Fetch only: read_mem_ir=1, addresses 0..3 with INIT_FILE preloaded -> instruction_fetch equals mem[0..3] on cycles 1..4, ir_valid=1, fetch_stall=0.
- Store then fetch stall: write_mem pulse to addr 5 with data 32'hA5A5_0001 while fetching, buffer empty -> enqueue with no stall; the DRAIN happens in the first cycle read_mem_ir=0; a later read of addr 5 returns 32'hA5A5_0001.
- Buffer full: 5 back-to-back stores with read_mem_ir=1 -> sb_full=1 after the 4th; the 5th cycle is DRAIN with enqueue, sb_count stays 4, fetch_stall=1; no store is lost (verify RAM contents afterwards).
- Load hazard: store 32'hDEAD_BEEF to addr 9, then load addr 9 in the next cycle:
  - With STORE_FORWARD_EN -> ld_valid at N+1 with 32'hDEAD_BEEF, no DRAIN.
  - Without -> ld_stall=1 until the entry drains, then 32'hDEAD_BEEF returned.
- Same-address ordering: stores to addr 3 of 1, then 2, then a load of addr 3 -> returns 2 in both builds; RAM[3]=2 after drain.
- Reset mid-operation: 3 entries buffered, assert reset for 1 cycle -> sb_count=0, sb_empty=1, ir_valid=0, ld_valid=0; none of the 3 addresses is written.

Source files
------------

// File: rtl/unified_mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared types and constants for the unified memory controller
package mem_ctrl_pkg;
    localparam int ADDR_W_DEF = 11;
    localparam int DATA_W_DEF = 32;
    localparam logic [DATA_W_DEF-1:0] NOOP_WORD = 32'h0;
    typedef enum logic [1:0] {GNT_IDLE, GNT_FETCH, GNT_LOAD, GNT_DRAIN} gnt_t;
    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } sb_entry_t;
endpackage

// File: rtl/unified_mem_ctrl_store_buffer.sv
// store_buffer: circular store FIFO with a parallel address CAM
// Ports: enq/enq_entry push at tail, deq pops head; lookup_addr is matched
// against all valid entries, hit/hit_data report the youngest match;
// head_entry, count, full, empty expose FIFO state.
module store_buffer import mem_ctrl_pkg::*; #(
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enq,
    input  sb_entry_t                     enq_entry,
    input  logic                          deq,
    input  logic [ADDR_W_DEF-1:0]         lookup_addr,
    output logic                          hit,
    output logic [DATA_W_DEF-1:0]         hit_data,
    output sb_entry_t                     head_entry,
    output logic [$clog2(DEPTH+1)-1:0]    count,
    output logic                          full,
    output logic                          empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    sb_entry_t entries [DEPTH];
    logic [PW-1:0] head, tail;
    always_ff @(posedge clk) begin
        if (enq) entries[tail] <= enq_entry;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) tail <= tail + 1'b1;
            if (deq) head <= head + 1'b1;
            if (enq && !deq) count <= count + 1'b1;
            else if (deq && !enq) count <= count - 1'b1;
        end
    end
    // Walk oldest to youngest so the last match seen is the youngest.
    always_comb begin
        logic [PW-1:0] idx;
        hit      = 1'b0;
        hit_data = '0;
        idx      = head;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (i < int'(count) && entries[idx].addr == lookup_addr) begin
                hit      = 1'b1;
                hit_data = entries[idx].data;
            end
        end
    end
    assign head_entry = entries[head];
    assign full       = count == CW'(DEPTH);
    assign empty      = count == '0;
endmodule

// File: rtl/unified_mem_ctrl.sv
// unified_mem_ctrl: single-port instruction/data RAM with posted store buffer
module unified_mem_ctrl import mem_ctrl_pkg::*; #(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int SB_DEPTH  = 4,
  parameter     INIT_FILE = ""
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          read_mem_ir,
  input  logic [ADDR_W-1:0]             mem_radrs_ir,
  input  logic                          read_mem_str,
  input  logic [ADDR_W-1:0]             mem_radrs_LD,
  input  logic                          write_mem,
  input  logic [ADDR_W-1:0]             mem_wadrs,
  input  logic [DATA_W-1:0]             mem_wdata,
  output logic [DATA_W-1:0]             instruction_fetch,
  output logic                          ir_valid,
  output logic [DATA_W-1:0]             mem_store_data,
  output logic                          ld_valid,
  output logic                          fetch_stall,
  output logic                          ld_stall,
  output logic [$clog2(SB_DEPTH+1)-1:0] sb_count,
  output logic                          sb_full,
  output logic                          sb_empty
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  sb_entry_t head_e;
  logic sb_hit, st_match, any_match, ld_acc, ld_fwd, fwd_q;
  logic [DATA_W-1:0] sb_hit_data, rdata_q, fwd_data_q;
  gnt_t gnt, gnt_q;
  store_buffer #(.DEPTH(SB_DEPTH)) u_sb (
    .clk(clk), .reset(reset),
    .enq(write_mem), .enq_entry({mem_wadrs, mem_wdata}),
    .deq(gnt == GNT_DRAIN), .lookup_addr(mem_radrs_LD),
    .hit(sb_hit), .hit_data(sb_hit_data), .head_entry(head_e),
    .count(sb_count), .full(sb_full), .empty(sb_empty)
  );
  assign st_match  = write_mem && mem_wadrs == mem_radrs_LD;
  assign any_match = sb_hit || st_match;
`ifdef STORE_FORWARD_EN
  assign ld_acc = read_mem_str && (any_match || !sb_full);
  assign ld_fwd = ld_acc && any_match;
`else
  assign ld_acc = read_mem_str && !any_match && !sb_full;
  assign ld_fwd = 1'b0;
`endif
  assign gnt = sb_full                             ? GNT_DRAIN :
               (ld_acc && !ld_fwd)                 ? GNT_LOAD  :
               (read_mem_str && !ld_acc && sb_hit) ? GNT_DRAIN :
               read_mem_ir                         ? GNT_FETCH :
               !sb_empty                           ? GNT_DRAIN : GNT_IDLE;
  assign fetch_stall = read_mem_ir && gnt != GNT_FETCH;
  assign ld_stall    = read_mem_str && !ld_acc;
  always_ff @(posedge clk) begin
    if (!reset && gnt == GNT_DRAIN) mem[head_e.addr] <= head_e.data;
    rdata_q    <= mem[gnt == GNT_LOAD ? mem_radrs_LD : mem_radrs_ir];
    fwd_data_q <= st_match ? mem_wdata : sb_hit_data;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_q <= GNT_IDLE;
      fwd_q <= 1'b0;
    end else begin
      gnt_q <= gnt;
      fwd_q <= ld_fwd;
    end
  end
  assign ir_valid          = gnt_q == GNT_FETCH;
  assign ld_valid          = gnt_q == GNT_LOAD || fwd_q;
  assign instruction_fetch = ir_valid ? rdata_q : NOOP_WORD;
  assign mem_store_data    = !ld_valid ? '0 : fwd_q ? fwd_data_q : rdata_q;
endmodule

// File: tb/tb_unified_mem_ctrl.sv
// tb_unified_mem_ctrl: directed table-driven bench for unified_mem_ctrl
module tb_unified_mem_ctrl;
    logic clk = 1'b0;
    logic reset, read_mem_ir, read_mem_str, write_mem;
    logic [10:0] mem_radrs_ir, mem_radrs_LD, mem_wadrs;
    logic [31:0] mem_wdata, instruction_fetch, mem_store_data;
    logic ir_valid, ld_valid, fetch_stall, ld_stall, sb_full, sb_empty;
    logic [2:0] sb_count;
    int total = 0;
    int bad = 0;

    unified_mem_ctrl dut (
        .clk(clk), .reset(reset),
        .read_mem_ir(read_mem_ir), .mem_radrs_ir(mem_radrs_ir),
        .read_mem_str(read_mem_str), .mem_radrs_LD(mem_radrs_LD),
        .write_mem(write_mem), .mem_wadrs(mem_wadrs), .mem_wdata(mem_wdata),
        .instruction_fetch(instruction_fetch), .ir_valid(ir_valid),
        .mem_store_data(mem_store_data), .ld_valid(ld_valid),
        .fetch_stall(fetch_stall), .ld_stall(ld_stall),
        .sb_count(sb_count), .sb_full(sb_full), .sb_empty(sb_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic ir; logic [10:0] ia;
        logic ld; logic [10:0] la;
        logic wr; logic [10:0] wa; logic [31:0] wd;
        logic fs; logic ls;
        logic [2:0] cnt; logic irv; logic [31:0] ifd; logic ldv; logic [31:0] lsd;
    } vec_t;
    vec_t tv[$];

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    task automatic add(input logic ir, input logic [10:0] ia, input logic ld, input logic [10:0] la,
                       input logic wr, input logic [10:0] wa, input logic [31:0] wd,
                       input logic fs, input logic ls, input logic [2:0] cnt,
                       input logic irv, input logic [31:0] ifd, input logic ldv, input logic [31:0] lsd);
        vec_t v;
        v.ir = ir; v.ia = ia; v.ld = ld; v.la = la; v.wr = wr; v.wa = wa; v.wd = wd;
        v.fs = fs; v.ls = ls; v.cnt = cnt; v.irv = irv; v.ifd = ifd; v.ldv = ldv; v.lsd = lsd;
        tv.push_back(v);
    endtask

    task automatic drive(input logic ir, input logic [10:0] ia, input logic ld, input logic [10:0] la,
                         input logic wr, input logic [10:0] wa, input logic [31:0] wd);
        read_mem_ir = ir; mem_radrs_ir = ia;
        read_mem_str = ld; mem_radrs_LD = la;
        write_mem = wr; mem_wadrs = wa; mem_wdata = wd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        chk("rst sb_count", 32'(sb_count), 0);
        chk("rst sb_empty", 32'(sb_empty), 1);
        chk("rst sb_full", 32'(sb_full), 0);
        chk("rst ir_valid", 32'(ir_valid), 0);
        chk("rst ld_valid", 32'(ld_valid), 0);
        chk("rst instruction_fetch", instruction_fetch, 0);
        chk("rst mem_store_data", mem_store_data, 0);
        chk("rst fetch_stall", 32'(fetch_stall), 0);
        chk("rst ld_stall", 32'(ld_stall), 0);
        reset = 1'b0;

        //   ir ia  ld la  wr wa  wd            fs ls cnt irv ifd           ldv lsd
        // preload words 0..3 through the buffer
        add(0, 0,  0, 0,  1, 0,  32'h1111_1111, 0, 0, 1, 0, 0,            0, 0);
        add(0, 0,  0, 0,  1, 1,  32'h2222_2222, 0, 0, 1, 0, 0,            0, 0);
        add(0, 0,  0, 0,  1, 2,  32'h3333_3333, 0, 0, 1, 0, 0,            0, 0);
        add(0, 0,  0, 0,  1, 3,  32'h4444_4444, 0, 0, 1, 0, 0,            0, 0);
        add(0, 0,  0, 0,  0, 0,  0,             0, 0, 0, 0, 0,            0, 0);
        // fetch only
        add(1, 0,  0, 0,  0, 0,  0,             0, 0, 0, 1, 32'h1111_1111, 0, 0);
        add(1, 1,  0, 0,  0, 0,  0,             0, 0, 0, 1, 32'h2222_2222, 0, 0);
        add(1, 2,  0, 0,  0, 0,  0,             0, 0, 0, 1, 32'h3333_3333, 0, 0);
        add(1, 3,  0, 0,  0, 0,  0,             0, 0, 0, 1, 32'h4444_4444, 0, 0);
        // store while fetching, drain on first idle cycle, read back
        add(1, 0,  0, 0,  1, 5,  32'hA5A5_0001, 0, 0, 1, 1, 32'h1111_1111, 0, 0);
        add(1, 1,  0, 0,  0, 0,  0,             0, 0, 1, 1, 32'h2222_2222, 0, 0);
        add(0, 0,  0, 0,  0, 0,  0,             0, 0, 0, 0, 0,            0, 0);
        add(0, 0,  1, 5,  0, 0,  0,             0, 0, 0, 0, 0,            1, 32'hA5A5_0001);
        add(0, 0,  1, 0,  0, 0,  0,             0, 0, 0, 0, 0,            1, 32'h1111_1111);
        // buffer full: five stores while fetching
        add(1, 0,  0, 0,  1, 10, 32'h0000_000A, 0, 0, 1, 1, 32'h1111_1111, 0, 0);
        add(1, 0,  0, 0,  1, 11, 32'h0000_000B, 0, 0, 2, 1, 32'h1111_1111, 0, 0);
        add(1, 0,  0, 0,  1, 12, 32'h0000_000C, 0, 0, 3, 1, 32'h1111_1111, 0, 0);
        add(1, 0,  0, 0,  1, 13, 32'h0000_000D, 0, 0, 4, 1, 32'h1111_1111, 0, 0);
        add(1, 0,  0, 0,  1, 14, 32'h0000_000E, 1, 0, 4, 0, 0,            0, 0);
        add(0, 0,  0, 0,  0, 0,  0,             0, 0, 3, 0, 0,            0, 0);
        add(0, 0,  0, 0,  0, 0,  0,             0, 0, 2, 0, 0,            0, 0);
        add(0, 0,  0, 0,  0, 0,  0,             0, 0, 1, 0, 0,            0, 0);
        add(0, 0,  0, 0,  0, 0,  0,             0, 0, 0, 0, 0,            0, 0);
        for (int i = 0; i < 5; i++)
            add(0, 0, 1, 11'(10 + i), 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'(10 + i));
        // same-address ordering
        add(0, 0,  0, 0,  1, 3,  32'h0000_0001, 0, 0, 1, 0, 0,            0, 0);
        add(0, 0,  0, 0,  1, 3,  32'h0000_0002, 0, 0, 1, 0, 0,            0, 0);
`ifdef STORE_FORWARD_EN
        add(0, 0,  1, 3,  0, 0,  0,             0, 0, 0, 0, 0,            1, 32'h0000_0002);
`else
        add(0, 0,  1, 3,  0, 0,  0,             0, 1, 0, 0, 0,            0, 0);
`endif
        add(0, 0,  1, 3,  0, 0,  0,             0, 0, 0, 0, 0,            1, 32'h0000_0002);
        // load hazard on a buffered store, then same-cycle store hazard
        add(0, 0,  0, 0,  1, 9,  32'hDEAD_BEEF, 0, 0, 1, 0, 0,            0, 0);
`ifdef STORE_FORWARD_EN
        add(1, 0,  1, 9,  0, 0,  0,             0, 0, 1, 1, 32'h1111_1111, 1, 32'hDEAD_BEEF);
        add(0, 0,  1, 9,  0, 0,  0,             0, 0, 0, 0, 0,            1, 32'hDEAD_BEEF);
        add(0, 0,  1, 20, 1, 20, 32'h0000_0077, 0, 0, 1, 0, 0,            1, 32'h0000_0077);
        add(0, 0,  1, 20, 0, 0,  0,             0, 0, 0, 0, 0,            1, 32'h0000_0077);
`else
        add(1, 0,  1, 9,  0, 0,  0,             1, 1, 0, 0, 0,            0, 0);
        add(0, 0,  1, 9,  0, 0,  0,             0, 0, 0, 0, 0,            1, 32'hDEAD_BEEF);
        add(0, 0,  1, 20, 1, 20, 32'h0000_0077, 0, 1, 1, 0, 0,            0, 0);
        add(0, 0,  1, 20, 0, 0,  0,             0, 1, 0, 0, 0,            0, 0);
`endif
        add(0, 0,  1, 20, 0, 0,  0,             0, 0, 0, 0, 0,            1, 32'h0000_0077);

        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].ir, tv[i].ia, tv[i].ld, tv[i].la, tv[i].wr, tv[i].wa, tv[i].wd);
            #1;
            chk($sformatf("v%0d fetch_stall", i), 32'(fetch_stall), 32'(tv[i].fs));
            chk($sformatf("v%0d ld_stall", i), 32'(ld_stall), 32'(tv[i].ls));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d sb_count", i), 32'(sb_count), 32'(tv[i].cnt));
            chk($sformatf("v%0d sb_full", i), 32'(sb_full), 32'(tv[i].cnt == 3'd4));
            chk($sformatf("v%0d sb_empty", i), 32'(sb_empty), 32'(tv[i].cnt == 3'd0));
            chk($sformatf("v%0d ir_valid", i), 32'(ir_valid), 32'(tv[i].irv));
            chk($sformatf("v%0d instruction_fetch", i), instruction_fetch, tv[i].ifd);
            chk($sformatf("v%0d ld_valid", i), 32'(ld_valid), 32'(tv[i].ldv));
            chk($sformatf("v%0d mem_store_data", i), mem_store_data, tv[i].lsd);
        end

        // reset mid-operation: buffered stores must never reach RAM
        drive(0, 0, 0, 0, 1, 30, 32'hA0); tick();
        drive(0, 0, 0, 0, 1, 31, 32'hA1); tick();
        drive(0, 0, 0, 0, 1, 32, 32'hA2); tick();
        drive(0, 0, 0, 0, 0, 0, 0); tick(); tick();
        chk("pre sb_empty", 32'(sb_empty), 1);
        drive(1, 0, 0, 0, 1, 30, 32'hB0); tick();
        drive(1, 0, 0, 0, 1, 31, 32'hB1); tick();
        drive(1, 0, 0, 0, 1, 32, 32'hB2); tick();
        chk("pre-reset sb_count", 32'(sb_count), 3);
        drive(0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid-rst sb_count", 32'(sb_count), 0);
        chk("mid-rst sb_empty", 32'(sb_empty), 1);
        chk("mid-rst ir_valid", 32'(ir_valid), 0);
        chk("mid-rst ld_valid", 32'(ld_valid), 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 11'(30 + i), 0, 0, 0);
            tick();
            chk($sformatf("post-rst ld_valid a%0d", 30 + i), 32'(ld_valid), 1);
            chk($sformatf("post-rst ram a%0d", 30 + i), mem_store_data, 32'(8'hA0 + i));
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
